glbl_rst_seq: RTL and testbench
===============================

GLBL_RST_SEQ -- requirements
Module: glbl_rst_seq

Interface
REQ-001 SHALL have parameter ROC_CYCLES, default 16: mclk cycles gsr_o/prld_o are held after sequence start; legal range 1..2^CNT_W-1.
REQ-002 SHALL have parameter TOC_CYCLES, default 0: mclk cycles gts_o is held after gsr_o release; 0 is legal and skips the TOC phase.
REQ-003 SHALL have parameter CNT_W, default 16: phase counter width.
REQ-004 SHALL have port mclk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port restart_req  input  1  synchronous level request to rerun the sequence.
REQ-007 SHALL have port restart_ack  output  1  one-cycle pulse on request acceptance.
REQ-008 SHALL have port gsr_o  output  1  global set/reset, active high.
REQ-009 SHALL have port gts_o  output  1  global tristate, active high.
REQ-010 SHALL have port prld_o  output  1  global preload, active high.
REQ-011 SHALL have port seq_done_o  output  1  high while sequence is complete (RUN).
REQ-012 SHALL have port state_o  output  2  current FSM state encoding.

Function
REQ-013 SHALL implement FSM states ROC=2'd0, TOC=2'd1, RUN=2'd2; 2'd3 unreachable, recovers to ROC.
REQ-014 In ROC, outputs SHALL be gsr_o=1, prld_o=1, gts_o=1, seq_done_o=0.
REQ-015 In TOC, outputs SHALL be gsr_o=0, prld_o=0, gts_o=1, seq_done_o=0.
REQ-016 In RUN, outputs SHALL be gsr_o=0, prld_o=0, gts_o=0, seq_done_o=1.
REQ-017 All outputs SHALL be registered (decoded from state register only), no combinational path from restart_req except none; restart_ack registered.
REQ-018 In ROC, counter SHALL increment each edge; at cnt==ROC_CYCLES-1 it SHALL clear and state SHALL move to TOC, or to RUN if TOC_CYCLES==0.
REQ-019 In TOC, counter SHALL increment each edge; at cnt==TOC_CYCLES-1 it SHALL clear and state SHALL move to RUN.
REQ-020 Consequence: gsr_o high exactly ROC_CYCLES edges after reset release; gts_o high exactly ROC_CYCLES+TOC_CYCLES edges.
REQ-021 In RUN with restart_req=1, next edge SHALL enter ROC, clear counter, and assert restart_ack for exactly that one cycle.
REQ-022 restart_req in ROC/TOC SHALL be ignored (no ack, no counter restart); if still high on entry to RUN it SHALL be accepted on the first RUN edge (RUN lasts one cycle).
REQ-023 restart_req held high continuously SHALL cause back-to-back sequences, one ack per sequence.
REQ-024 Counter SHALL never exceed max(ROC_CYCLES,TOC_CYCLES)-1; no wrap.

Reset
REQ-025 reset_n low SHALL immediately (asynchronously) force state=ROC, cnt=0, restart_ack=0, gsr_o=1, prld_o=1 (0 if macro absent), gts_o=1, seq_done_o=0.
REQ-026 reset_n asserted mid-sequence SHALL abandon it; sequence restarts from ROC cnt=0 on release.

Configuration
REQ-027 Macro GLBL_PRLD_EN defined: prld_o SHALL track gsr_o per REQ-014..016.
REQ-028 Macro GLBL_PRLD_EN undefined: prld_o SHALL be tied 0 at all times, including reset; port retained.

Structure
REQ-029 Package glbl_rst_pkg SHALL hold the state enum type and state encoding constants; CNT_W default as package constant.
REQ-030 Single module, no sub-module; counter and FSM inline.

Verification
REQ-031 Defaults, release reset_n -> gsr_o/prld_o/gts_o fall after exactly 16 edges, seq_done_o rises same edge.
REQ-032 ROC_CYCLES=4, TOC_CYCLES=3 -> gsr_o low after edge 4, gts_o low after edge 7, state_o 0->1->2.
REQ-033 In RUN, 1-cycle restart_req -> restart_ack 1 cycle, gsr_o high 16 cycles, seq_done_o low.
REQ-034 restart_req pulsed during ROC at cnt=5 -> ignored, gsr_o still falls at cnt 15, no ack.
REQ-035 reset_n low at TOC cnt=1 -> outputs return to reset values immediately; full sequence reruns after release.
REQ-036 Build without GLBL_PRLD_EN -> prld_o 0 throughout REQ-031 scenario.

Source files
------------

// File: rtl/glbl_rst_pkg.sv
// Shared definitions for the global reset sequencer: state encoding and
// the default phase counter width.
package glbl_rst_pkg;

  // Default width of the phase counter.
  localparam int unsigned CNT_W_DEF = 16;

  // Sequencer states. ST_BAD is never entered and recovers to ST_ROC.
  typedef enum logic [1:0] {
    ST_ROC = 2'd0,
    ST_TOC = 2'd1,
    ST_RUN = 2'd2,
    ST_BAD = 2'd3
  } state_t;

  // Raw encodings for consumers that only see the state_o bus.
  localparam logic [1:0] ENC_ROC = 2'd0;
  localparam logic [1:0] ENC_TOC = 2'd1;
  localparam logic [1:0] ENC_RUN = 2'd2;

endpackage

// File: rtl/glbl_rst_seq.sv
// Global reset sequencer.
// It holds GSR, PRLD and GTS high for ROC_CYCLES clocks.
// It then holds GTS high alone for TOC_CYCLES clocks, and then reports
// the sequence as complete (RUN).
// A restart request is accepted only while in RUN.
// Optional build macro GLBL_PRLD_EN: when it is defined, prld_o follows gsr_o.
// When it is undefined, prld_o is tied low.
module glbl_rst_seq
  import glbl_rst_pkg::*;
#(
  parameter int unsigned ROC_CYCLES = 16,
  parameter int unsigned TOC_CYCLES = 0,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic       restart_req,
  output logic       restart_ack,
  output logic       gsr_o,
  output logic       gts_o,
  output logic       prld_o,
  output logic       seq_done_o,
  output logic [1:0] state_o
);

  // Terminal counts. A zero-length TOC phase is never counted, so clamp it.
  localparam logic [CNT_W-1:0] ROC_LAST = CNT_W'(ROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOC_LAST = CNT_W'((TOC_CYCLES == 0) ? 0 : TOC_CYCLES - 1);
  localparam bit               TOC_SKIP = (TOC_CYCLES == 0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ack_r;
  logic             gsr_s;
  logic             gts_s;
  logic             done_s;

  // Phase FSM with inline counter; ack pulses on the edge a restart is taken.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_ROC;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_ROC: begin
          ack_r <= 1'b0;
          if (cnt_r == ROC_LAST) begin
            cnt_r   <= '0;
            state_r <= TOC_SKIP ? ST_RUN : ST_TOC;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_TOC: begin
          ack_r <= 1'b0;
          if (cnt_r == TOC_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_RUN;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt_r <= '0;
          if (restart_req) begin
            state_r <= ST_ROC;
            ack_r   <= 1'b1;
          end else begin
            ack_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_ROC;
          cnt_r   <= '0;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Output decode from the state register only; the unused code behaves like ROC.
  always_comb begin
    gsr_s  = 1'b1;
    gts_s  = 1'b1;
    done_s = 1'b0;
    case (state_r)
      ST_ROC: begin
        gsr_s  = 1'b1;
        gts_s  = 1'b1;
        done_s = 1'b0;
      end
      ST_TOC: begin
        gsr_s  = 1'b0;
        gts_s  = 1'b1;
        done_s = 1'b0;
      end
      ST_RUN: begin
        gsr_s  = 1'b0;
        gts_s  = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        gsr_s  = 1'b1;
        gts_s  = 1'b1;
        done_s = 1'b0;
      end
    endcase
  end

  assign restart_ack = ack_r;
  assign gsr_o       = gsr_s;
  assign gts_o       = gts_s;
  assign seq_done_o  = done_s;
  assign state_o     = state_r;

`ifdef GLBL_PRLD_EN
  assign prld_o = gsr_s;
`else
  assign prld_o = 1'b0;
`endif

endmodule

// File: tb/tb_glbl_rst_seq.sv
// Self-checking bench for glbl_rst_seq.
// It drives a default instance (16/0) and a short instance (4/3).
// Expected outputs come from a timeline model: the number of edges since
// the start of the sequence determines the phase.
module tb_glbl_rst_seq;

  logic       mclk = 1'b0;
  logic [1:0] rst_n_v;
  logic [1:0] req_v;

  logic       a_ack, a_gsr, a_gts, a_prld, a_done;
  logic [1:0] a_state;
  logic       b_ack, b_gsr, b_gts, b_prld, b_done;
  logic [1:0] b_state;

  int checks   = 0;
  int failures = 0;

  int   roc_p [2] = '{16, 4};
  int   toc_p [2] = '{0, 3};
  int   m_e   [2];
  logic m_ack [2];

  typedef struct {
    int         idx;
    logic [6:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 mclk = ~mclk;

  glbl_rst_seq u_a (
    .mclk(mclk), .reset_n(rst_n_v[0]), .restart_req(req_v[0]),
    .restart_ack(a_ack), .gsr_o(a_gsr), .gts_o(a_gts), .prld_o(a_prld),
    .seq_done_o(a_done), .state_o(a_state)
  );

  glbl_rst_seq #(.ROC_CYCLES(4), .TOC_CYCLES(3)) u_b (
    .mclk(mclk), .reset_n(rst_n_v[1]), .restart_req(req_v[1]),
    .restart_ack(b_ack), .gsr_o(b_gsr), .gts_o(b_gts), .prld_o(b_prld),
    .seq_done_o(b_done), .state_o(b_state)
  );

  // Compare one observed vector against its expectation.
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (state,gsr,gts,prld,done,ack)", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] obs(input int idx);
    if (idx == 0) return {a_state, a_gsr, a_gts, a_prld, a_done, a_ack};
    else          return {b_state, b_gsr, b_gts, b_prld, b_done, b_ack};
  endfunction

  function automatic logic [1:0] m_state(input int idx);
    if (m_e[idx] < roc_p[idx])                     return 2'd0;
    else if (m_e[idx] < roc_p[idx] + toc_p[idx])   return 2'd1;
    else                                           return 2'd2;
  endfunction

  function automatic logic [6:0] exp_vec(input int idx);
    logic [1:0] st;
    logic       gsr;
    logic       prld;
    st  = m_state(idx);
    gsr = (st == 2'd0);
`ifdef GLBL_PRLD_EN
    prld = gsr;
`else
    prld = 1'b0;
`endif
    return {st, gsr, (st != 2'd2), prld, (st == 2'd2), m_ack[idx]};
  endfunction

  // Advance the model over one edge, queue expectations, then compare after the edge.
  task automatic cycle(input string tag);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_v[i]) begin
        m_e[i]   = 0;
        m_ack[i] = 1'b0;
      end else if (m_state(i) == 2'd2 && req_v[i]) begin
        m_e[i]   = 0;
        m_ack[i] = 1'b1;
      end else begin
        if (m_e[i] < roc_p[i] + toc_p[i]) m_e[i] = m_e[i] + 1;
        m_ack[i] = 1'b0;
      end
      e.idx = i;
      e.v   = exp_vec(i);
      sb.push_back(e);
    end
    @(posedge mclk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_%s", tag, (e.idx == 0) ? "a" : "b"), obs(e.idx), e.v);
    end
  endtask

  task automatic cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  // Assert reset mid-cycle and check that outputs change without a clock edge.
  task automatic async_reset(input int idx);
    #2;
    rst_n_v[idx] = 1'b0;
    #1;
    m_e[idx]   = 0;
    m_ack[idx] = 1'b0;
    chk("rst_async", obs(idx), exp_vec(idx));
  endtask

  initial begin
    rst_n_v = 2'b00;
    req_v   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_e[i]   = 0;
      m_ack[i] = 1'b0;
    end
    #2;
    chk("reset_a", obs(0), exp_vec(0));
    chk("reset_b", obs(1), exp_vec(1));
    cycles("in_reset", 2);
    rst_n_v = 2'b11;

    // First sequence: A falls after 16 edges, B walks 0->1->2 at edges 4 and 7.
    cycles("seq1", 22);

    // One-cycle restart on A in RUN, then a request pulse at ROC cnt=5 that is ignored.
    req_v[0] = 1'b1;
    cycle("restart_a");
    req_v[0] = 1'b0;
    cycles("roc_a", 5);
    req_v[0] = 1'b1;
    cycle("ign_req_a");
    req_v[0] = 1'b0;
    cycles("roc_a_tail", 15);

    // Continuous request on B: back-to-back sequences with one ack each.
    req_v[1] = 1'b1;
    cycles("hold_b", 25);
    req_v[1] = 1'b0;
    cycles("hold_b_end", 10);

    // Restart B, stop at TOC cnt=1, and apply an asynchronous reset there.
    req_v[1] = 1'b1;
    cycle("restart_b");
    req_v[1] = 1'b0;
    for (int k = 0; k < 20 && m_e[1] != roc_p[1] + 1; k++) cycle("to_toc_b");
    chk("toc_cnt1_state_b", {5'd0, b_state}, 7'd1);
    async_reset(1);
    cycles("rst_hold_b", 2);
    rst_n_v[1] = 1'b1;
    cycles("rerun_b", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
